wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the ALU, MEM and CSR result producers.
//  Each producer gets a 1-entry holding buffer with a valid/ok handshake.
//  A priority arbiter with starvation aging selects one buffer per cycle and drives the write port.
//  CSR exceptions flush pending ALU/MEM results.
//  Sits between the execute units and the register manager, in place of a purely combinational write-back mux.
// PARAMETERS
//  XLEN          32  result data width
//  STARVE_LIMIT   4  wait cycles after which a pending entry overrides fixed priority (>=1)
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst            in   1     reset; asynchronous, active-high
//  alu_res        in   XLEN  ALU result
//  alu_rd         in   5     ALU destination register
//  alu_res_v      in   1     ALU result valid
//  alu_ok         out  1     ALU transfer accepted this cycle (ready)
//  mem_res/mem_rd/mem_res_v/mem_ok   as ALU, for MEM stage
//  csr_res/csr_rd/csr_res_v/csr_ok   as ALU, for CSR unit
//  csr_exception  in   1     CSR unit signals exception this cycle
//  result         out  XLEN  write data to register manager
//  rd             out  5     write address
//  result_v       out  1     write enable; register manager writes at this edge
//  stall_cnt      out  8     saturating count of cycles with >=2 buffers pending (perf)
// BEHAVIOUR
//  Reset (async, rst=1): all buffers invalid, wait counters 0, stall_cnt 0.
//   Outputs: result_v=0, result=0, rd=0, all *_ok=1.
//  Handshake: transfer when X_res_v && X_ok at clock edge.
//   X_ok = !bufX_v || grantX. Depends on state and grant only; no comb path from X_res_v.
//   Producers hold res/rd stable while res_v && !ok.
//  rd==0 transfers are accepted per ok and discarded; the buffer is not loaded. Never appear on the port.
//  Latency: transfer at edge N -> result_v=1 in cycle N+1 at the earliest -> written at edge N+1.
//   Back-to-back from one uncontested source: 1 result/cycle.
//  Arbitration (comb, from buffer state):
//   - Starved set S = valid buffers whose wait counter == STARVE_LIMIT.
//   - If S is non-empty, grant the highest of S in CSR>MEM>ALU order.
//   - Otherwise grant the highest valid buffer in CSR>MEM>ALU order.
//   - At most one grant per cycle.
//   - result/rd/result_v come from the granted buffer. With no grant: result_v=0, result/rd hold 0.
//  Wait counters: +1 (saturating at STARVE_LIMIT) each cycle buffer valid && not granted.
//   Cleared on grant or flush.
//  Simultaneous grant + new transfer on same source: the buffer is reloaded at the same edge (no bubble).
//  Exception flush: csr_exception=1 in a cycle ->
//   - ALU and MEM buffers and their counters cleared at that edge.
//   - Any ALU/MEM grant that cycle is suppressed: result_v=0 unless CSR is granted; CSR then keeps priority.
//   - alu_ok=mem_ok=0 that cycle, so no new ALU/MEM transfer.
//   - CSR buffer and csr_ok are unaffected.
//  stall_cnt: +1 per cycle with >=2 valid buffers, saturates at 255. Cleared only by reset.
//  Reset mid-operation: all pending results dropped immediately. Nothing written after rst rises.
// TESTING
//  1 Reset values.
//    Assert rst mid-stream with all 3 buffers full -> same cycle result_v=0, *_ok=1.
//    After release, no stale write appears.
//  2 ALU only: results A=0x11/x5, B=0x22/x6 on consecutive cycles.
//    -> result_v in the next two cycles with (0x11,x5), (0x22,x6); alu_ok stays 1.
//  3 CSR (0xC,x3), MEM (0xB,x2), ALU (0xA,x1) all in one cycle.
//    -> writes in order x3, x2, x1 over 3 cycles; stall_cnt=2.
//  4 Starvation, STARVE_LIMIT=4: ALU pending while MEM streams every cycle.
//    -> ALU granted on the 5th cycle of waiting, ahead of the pending MEM entry.
//  5 csr_exception with ALU and MEM buffers full and CSR valid.
//    -> only the CSR result is written; ALU/MEM never written; alu_ok=mem_ok=0 that cycle, 1 after.
//  6 ALU transfer with rd=x0, value 0xFFFF -> alu_ok=1, no result_v pulse, buffer stays empty.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bundles the three producer handshakes, the exception strobe and the register-file write port.
// Pure wiring with no state and no latency.
// Backpressure is carried by the *_ok signals back to the producers.
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] alu_res;
  logic [4:0]      alu_rd;
  logic            alu_res_v;
  logic            alu_ok;

  logic [XLEN-1:0] mem_res;
  logic [4:0]      mem_rd;
  logic            mem_res_v;
  logic            mem_ok;

  logic [XLEN-1:0] csr_res;
  logic [4:0]      csr_rd;
  logic            csr_res_v;
  logic            csr_ok;
  logic            csr_exception;

  logic [XLEN-1:0] result;
  logic [4:0]      rd;
  logic            result_v;
  logic [7:0]      stall_cnt;

  // Arbiter side
  modport slave (
    input  alu_res, alu_rd, alu_res_v,
    input  mem_res, mem_rd, mem_res_v,
    input  csr_res, csr_rd, csr_res_v, csr_exception,
    output alu_ok, mem_ok, csr_ok,
    output result, rd, result_v, stall_cnt
  );

  // Producer / register-manager side
  modport master (
    output alu_res, alu_rd, alu_res_v,
    output mem_res, mem_rd, mem_res_v,
    output csr_res, csr_rd, csr_res_v, csr_exception,
    input  alu_ok, mem_ok, csr_ok,
    input  result, rd, result_v, stall_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between ALU, MEM and CSR via 1-entry buffers and an aging priority arbiter.
// Latency: transfer at edge N gives result_v in cycle N+1 at the earliest; 1 result/cycle from an uncontested source.
// Backpressure: X_ok = !buffer_valid || granted (ALU/MEM forced low on csr_exception); never depends on X_res_v.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  wb_port_arbiter_if.slave bus
);

  localparam int ALU = 0;
  localparam int MEM = 1;
  localparam int CSR = 2;
  localparam int CW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // Producer inputs gathered into arrays so every source is handled by the same loop
  logic [XLEN-1:0] in_res [3];
  logic [4:0]      in_rd  [3];
  logic [2:0]      in_v;

  assign in_res[ALU] = bus.alu_res;
  assign in_res[MEM] = bus.mem_res;
  assign in_res[CSR] = bus.csr_res;
  assign in_rd[ALU]  = bus.alu_rd;
  assign in_rd[MEM]  = bus.mem_rd;
  assign in_rd[CSR]  = bus.csr_rd;
  assign in_v        = {bus.csr_res_v, bus.mem_res_v, bus.alu_res_v};

  logic [2:0]      buf_v;
  logic [XLEN-1:0] buf_res  [3];
  logic [4:0]      buf_rd   [3];
  logic [CW-1:0]   wait_cnt [3];

  logic [2:0]      eligible;
  logic [2:0]      starved;
  logic [2:0]      cand;
  logic [2:0]      grant;
  logic [2:0]      ok;
  logic [2:0]      xfer;
  logic [2:0]      flush;

  logic [XLEN-1:0] wr_res;
  logic [4:0]      wr_rd;
  logic            wr_v;
  logic [7:0]      stall_q;

  // An exception removes ALU/MEM from contention so only CSR can reach the port that cycle
  assign flush = bus.csr_exception ? 3'b011 : 3'b000;

  // Pick one buffer: starved entries first, then fixed CSR > MEM > ALU priority
  always_comb begin
    eligible = buf_v & ~flush;
    starved  = '0;
    for (int i = 0; i < 3; i++) begin
      if (eligible[i] && (wait_cnt[i] == LIMIT)) begin
        starved[i] = 1'b1;
      end
    end
    cand  = (starved != 3'b000) ? starved : eligible;
    grant = '0;
    if (cand[CSR]) begin
      grant[CSR] = 1'b1;
    end else if (cand[MEM]) begin
      grant[MEM] = 1'b1;
    end else if (cand[ALU]) begin
      grant[ALU] = 1'b1;
    end
  end

  // Ready when the buffer is free or drains this cycle; flushed sources take nothing new
  always_comb begin
    ok = '0;
    for (int i = 0; i < 3; i++) begin
      ok[i] = (!buf_v[i] || grant[i]) && !flush[i];
    end
  end

  assign xfer = in_v & ok;

  // Write port is driven from the granted buffer, zero when idle
  always_comb begin
    wr_res = '0;
    wr_rd  = '0;
    wr_v   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) begin
        wr_res = buf_res[i];
        wr_rd  = buf_rd[i];
        wr_v   = 1'b1;
      end
    end
  end

  // Buffer load/drain and wait-counter aging; a reload on the grant edge avoids a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v <= '0;
      for (int i = 0; i < 3; i++) begin
        buf_res[i]  <= '0;
        buf_rd[i]   <= '0;
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (flush[i]) begin
          buf_v[i]    <= 1'b0;
          wait_cnt[i] <= '0;
        end else if (xfer[i] && (in_rd[i] != 5'd0)) begin
          buf_v[i]    <= 1'b1;
          buf_res[i]  <= in_res[i];
          buf_rd[i]   <= in_rd[i];
          wait_cnt[i] <= '0;
        end else if (grant[i]) begin
          // Drained, and any concurrent x0 transfer is simply dropped
          buf_v[i]    <= 1'b0;
          wait_cnt[i] <= '0;
        end else if (buf_v[i] && (wait_cnt[i] != LIMIT)) begin
          wait_cnt[i] <= wait_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Perf counter: cycles with two or more results competing for the port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (((buf_v[0] & buf_v[1]) | (buf_v[0] & buf_v[2]) | (buf_v[1] & buf_v[2]))
                 && (stall_q != 8'hFF)) begin
      stall_q <= stall_q + 8'd1;
    end
  end

  assign bus.alu_ok    = ok[ALU];
  assign bus.mem_ok    = ok[MEM];
  assign bus.csr_ok    = ok[CSR];
  assign bus.result    = wr_res;
  assign bus.rd        = wr_rd;
  assign bus.result_v  = wr_v;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: per-cycle vector table for handshakes plus a write scoreboard.
// Vectors are driven 1 time unit after the rising edge and checked on the falling edge.
// Expected writes are queued as stimulus is driven and popped as the port writes.
module tb_wb_port_arbiter;

  logic clk;
  logic rst;

  wb_port_arbiter_if #(.XLEN(32)) bus ();

  wb_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
  } wr_t;

  wr_t sb[$];

  typedef struct {
    logic [2:0]  v;      // {csr, mem, alu} res_v
    logic [4:0]  crd;
    logic [31:0] cres;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic [4:0]  ard;
    logic [31:0] ares;
    logic        exc;
    logic [2:0]  exp_ok; // {csr_ok, mem_ok, alu_ok}
    logic        exp_rv;
    logic        push;
    logic [4:0]  prd;
    logic [31:0] pres;
  } vec_t;

  vec_t vecs[28];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v,
                              input logic [4:0] crd, input logic [31:0] cres,
                              input logic [4:0] mrd, input logic [31:0] mres,
                              input logic [4:0] ard, input logic [31:0] ares,
                              input logic exc, input logic [2:0] exp_ok, input logic exp_rv,
                              input logic push, input logic [4:0] prd, input logic [31:0] pres);
    vec_t t;
    t.v = v; t.crd = crd; t.cres = cres; t.mrd = mrd; t.mres = mres;
    t.ard = ard; t.ares = ares; t.exc = exc; t.exp_ok = exp_ok; t.exp_rv = exp_rv;
    t.push = push; t.prd = prd; t.pres = pres;
    return t;
  endfunction

  function automatic vec_t idle(input logic exc, input logic [2:0] exp_ok, input logic exp_rv,
                                input logic push, input logic [4:0] prd, input logic [31:0] pres);
    return mk(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, exc, exp_ok, exp_rv, push, prd, pres);
  endfunction

  task automatic drive(input vec_t t);
    bus.csr_res_v     = t.v[2];
    bus.csr_rd        = t.crd;
    bus.csr_res       = t.cres;
    bus.mem_res_v     = t.v[1];
    bus.mem_rd        = t.mrd;
    bus.mem_res       = t.mres;
    bus.alu_res_v     = t.v[0];
    bus.alu_rd        = t.ard;
    bus.alu_res       = t.ares;
    bus.csr_exception = t.exc;
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      if (vecs[i].push) sb.push_back('{rd: vecs[i].prd, res: vecs[i].pres});
      @(negedge clk);
      check($sformatf("v%0d_ok", i), 64'({bus.csr_ok, bus.mem_ok, bus.alu_ok}), 64'(vecs[i].exp_ok));
      check($sformatf("v%0d_result_v", i), 64'(bus.result_v), 64'(vecs[i].exp_rv));
    end
  endtask

  // Scoreboard: every write must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && bus.result_v) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got rd=%0d result=0x%0h, expected no write (t=%0t)",
                 bus.rd, bus.result, $time);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write", {27'd0, bus.rd, bus.result}, {27'd0, e.rd, e.res});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ALU stream (0x11,x5) then (0x22,x6)
    vecs[0]  = mk(3'b001, 0, 0, 0, 0, 5'd5, 32'h11, 0, 3'b111, 0, 1, 5'd5, 32'h11);
    vecs[1]  = mk(3'b001, 0, 0, 0, 0, 5'd6, 32'h22, 0, 3'b111, 1, 1, 5'd6, 32'h22);
    vecs[2]  = idle(0, 3'b111, 1, 0, 0, 0);
    vecs[3]  = idle(0, 3'b111, 0, 0, 0, 0);
    // All three at once: CSR, MEM, ALU order
    vecs[4]  = mk(3'b111, 5'd3, 32'hC, 5'd2, 32'hB, 5'd1, 32'hA, 0, 3'b111, 0, 1, 5'd3, 32'hC);
    vecs[5]  = idle(0, 3'b100, 1, 1, 5'd2, 32'hB);
    vecs[6]  = idle(0, 3'b110, 1, 1, 5'd1, 32'hA);
    vecs[7]  = idle(0, 3'b111, 1, 0, 0, 0);
    vecs[8]  = idle(0, 3'b111, 0, 0, 0, 0);
    // Starvation: ALU waits while MEM streams; ALU wins in its 5th waiting cycle
    vecs[9]  = mk(3'b011, 0, 0, 5'd8, 32'hB0, 5'd7, 32'hA1, 0, 3'b111, 0, 1, 5'd8, 32'hB0);
    vecs[10] = mk(3'b010, 0, 0, 5'd8, 32'hB1, 0, 0, 0, 3'b110, 1, 1, 5'd8, 32'hB1);
    vecs[11] = mk(3'b010, 0, 0, 5'd8, 32'hB2, 0, 0, 0, 3'b110, 1, 1, 5'd8, 32'hB2);
    vecs[12] = mk(3'b010, 0, 0, 5'd8, 32'hB3, 0, 0, 0, 3'b110, 1, 1, 5'd8, 32'hB3);
    vecs[13] = mk(3'b010, 0, 0, 5'd8, 32'hB4, 0, 0, 0, 3'b110, 1, 1, 5'd7, 32'hA1);
    vecs[14] = mk(3'b010, 0, 0, 5'd8, 32'hB5, 0, 0, 0, 3'b101, 1, 1, 5'd8, 32'hB4);
    vecs[15] = mk(3'b010, 0, 0, 5'd8, 32'hB5, 0, 0, 0, 3'b111, 1, 1, 5'd8, 32'hB5);
    vecs[16] = idle(0, 3'b111, 1, 0, 0, 0);
    vecs[17] = idle(0, 3'b111, 0, 0, 0, 0);
    // Exception with all buffers full: only CSR written
    vecs[18] = mk(3'b111, 5'd9, 32'hC5, 5'd10, 32'hB9, 5'd11, 32'hA9, 0, 3'b111, 0, 1, 5'd9, 32'hC5);
    vecs[19] = idle(1, 3'b100, 1, 0, 0, 0);
    vecs[20] = idle(0, 3'b111, 0, 0, 0, 0);
    vecs[21] = idle(0, 3'b111, 0, 0, 0, 0);
    // Exception with only ALU pending: no write at all
    vecs[22] = mk(3'b001, 0, 0, 0, 0, 5'd12, 32'hAA, 0, 3'b111, 0, 0, 0, 0);
    vecs[23] = idle(1, 3'b100, 0, 0, 0, 0);
    vecs[24] = idle(0, 3'b111, 0, 0, 0, 0);
    // rd = x0 is accepted and discarded
    vecs[25] = mk(3'b001, 0, 0, 0, 0, 5'd0, 32'hFFFF, 0, 3'b111, 0, 0, 0, 0);
    vecs[26] = idle(0, 3'b111, 0, 0, 0, 0);
    vecs[27] = idle(0, 3'b111, 0, 0, 0, 0);

    rst = 1'b1;
    drive(idle(0, 3'b111, 0, 0, 0, 0));
    #3;
    check("rst_result_v", 64'(bus.result_v), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_rd", 64'(bus.rd), 64'd0);
    check("rst_ok", 64'({bus.csr_ok, bus.mem_ok, bus.alu_ok}), 64'd7);
    check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_vectors(0, 8);
    check("stall_cnt_after_3way", 64'(bus.stall_cnt), 64'd2);
    run_vectors(9, 27);
    check("idle_result", 64'(bus.result), 64'd0);
    check("idle_rd", 64'(bus.rd), 64'd0);

    // Reset asserted mid-cycle with all three buffers loaded
    @(posedge clk);
    #1;
    drive(mk(3'b111, 5'd13, 32'hD1, 5'd14, 32'hD2, 5'd15, 32'hD3, 0, 3'b111, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    drive(idle(0, 3'b111, 0, 0, 0, 0));
    check("full_before_rst_ok", 64'({bus.csr_ok, bus.mem_ok, bus.alu_ok}), 64'b100);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_result_v", 64'(bus.result_v), 64'd0);
    check("mid_rst_ok", 64'({bus.csr_ok, bus.mem_ok, bus.alu_ok}), 64'd7);
    check("mid_rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_result_v_%0d", i), 64'(bus.result_v), 64'd0);
    end

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
